// File: rtl/pc_unit_if.sv
// Bundle between the PC unit and its consumers: control inputs in, PC/RAS status out.
// The exc_req line exists only when PC_UNIT_EXC_EN is defined.
interface pc_unit_if;
    logic        stall;
    logic [2:0]  npc_op;
    logic        br_taken;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] addr;
`ifdef PC_UNIT_EXC_EN
    logic        exc_req;
`endif
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] pc4;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_miss;

`ifdef PC_UNIT_EXC_EN
    modport master (output stall, npc_op, br_taken, imm16, imm26, addr, exc_req,
                    input  pc, npc, pc4, ras_empty, ras_full, ras_miss);
    modport slave  (input  stall, npc_op, br_taken, imm16, imm26, addr, exc_req,
                    output pc, npc, pc4, ras_empty, ras_full, ras_miss);
`else
    modport master (output stall, npc_op, br_taken, imm16, imm26, addr,
                    input  pc, npc, pc4, ras_empty, ras_full, ras_miss);
    modport slave  (input  stall, npc_op, br_taken, imm16, imm26, addr,
                    output pc, npc, pc4, ras_empty, ras_full, ras_miss);
`endif
endinterface

// File: rtl/pc_unit.sv
// Program counter with next-PC selection and a circular return-address stack.
// Optional exception vectoring is enabled by defining PC_UNIT_EXC_EN.
module pc_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter int          RAS_DEPTH  = 4,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
    input logic     clk,
    input logic     reset,
    pc_unit_if.slave bus
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

    localparam logic [2:0] OP_SEQ  = 3'b000;
    localparam logic [2:0] OP_BR   = 3'b001;
    localparam logic [2:0] OP_J    = 3'b010;
    localparam logic [2:0] OP_JR   = 3'b011;
    localparam logic [2:0] OP_JAL  = 3'b100;
    localparam logic [2:0] OP_JALR = 3'b101;
    localparam logic [2:0] OP_RET  = 3'b110;

    logic [31:0]      pc_q, pc_d;
    logic [PTR_W-1:0] top_q, top_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      ras_mem_q [RAS_DEPTH];
    logic             ras_wr_en;

    logic [31:0] npc, pc4, br_off, jmp_tgt, ras_top;
    logic        push, pop, flush, empty, full, miss;

    always_comb begin
        pc4     = pc_q + 32'd4;
        br_off  = {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
        jmp_tgt = {pc_q[31:28], bus.imm26, 2'b00};
        empty   = (cnt_q == '0);
        full    = (cnt_q == CNT_MAX);
        ras_top = ras_mem_q[top_q];
        push    = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
        case (bus.npc_op)
            OP_SEQ:  npc = pc4;
            OP_BR:   npc = bus.br_taken ? pc4 + br_off : pc4;
            OP_J:    npc = jmp_tgt;
            OP_JR:   npc = bus.addr;
            OP_JAL:  begin npc = jmp_tgt;  push = 1'b1; end
            OP_JALR: begin npc = bus.addr; push = 1'b1; end
            OP_RET:  begin npc = bus.addr; pop = !empty; end
            default: npc = RESET_PC;
        endcase
        // The stored entry is only compared while the stack is non-empty, so stale contents never leak.
        miss = (bus.npc_op == OP_RET) && !empty && (ras_top != bus.addr);
`ifdef PC_UNIT_EXC_EN
        if (bus.exc_req) begin
            npc   = EXC_VECTOR;
            flush = 1'b1;
        end
`endif
    end

    always_comb begin
        pc_d      = pc_q;
        top_d     = top_q;
        cnt_d     = cnt_q;
        ras_wr_en = 1'b0;
        if (flush) begin
            pc_d  = npc;
            top_d = '0;
            cnt_d = '0;
        end else if (!bus.stall) begin
            pc_d = npc;
            if (push) begin
                // A push onto a full stack overwrites the oldest entry; the count saturates.
                top_d     = top_q + PTR_W'(1);
                ras_wr_en = 1'b1;
                if (!full) cnt_d = cnt_q + CNT_W'(1);
            end else if (pop) begin
                top_d = top_q - PTR_W'(1);
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= RESET_PC;
            top_q <= '0;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            top_q <= top_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ras_wr_en) ras_mem_q[top_d] <= pc4;
    end

    assign bus.pc        = pc_q;
    assign bus.npc       = npc;
    assign bus.pc4       = pc4;
    assign bus.ras_empty = empty;
    assign bus.ras_full  = full;
    assign bus.ras_miss  = miss;

endmodule

// File: tb/tb_pc_unit.sv
// Randomized self-checking bench for pc_unit against a queue-based reference model.
module tb_pc_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] EXC_VEC  = 32'h0000_4180;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pc_unit_if bus();

    pc_unit #(.RESET_PC(RESET_PC), .RAS_DEPTH(DEPTH), .EXC_VECTOR(EXC_VEC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] m_pc;
    logic [31:0] m_ras[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_npc();
        logic [31:0] off;
        off = {{16{bus.imm16[15]}}, bus.imm16} << 2;
`ifdef PC_UNIT_EXC_EN
        if (bus.exc_req) return EXC_VEC;
`endif
        case (bus.npc_op)
            3'd0:    return m_pc + 32'd4;
            3'd1:    return bus.br_taken ? m_pc + 32'd4 + off : m_pc + 32'd4;
            3'd2,
            3'd4:    return {m_pc[31:28], bus.imm26, 2'b00};
            3'd7:    return RESET_PC;
            default: return bus.addr;
        endcase
    endfunction

    function automatic logic m_miss();
        if (bus.npc_op != 3'd6 || m_ras.size() == 0) return 1'b0;
        return m_ras[$] != bus.addr;
    endfunction

    task automatic compare_all();
        chk("pc",        bus.pc,  m_pc);
        chk("npc",       bus.npc, m_npc());
        chk("pc4",       bus.pc4, m_pc + 32'd4);
        chk("ras_empty", {31'b0, bus.ras_empty}, {31'b0, m_ras.size() == 0});
        chk("ras_full",  {31'b0, bus.ras_full},  {31'b0, m_ras.size() == DEPTH});
        chk("ras_miss",  {31'b0, bus.ras_miss},  {31'b0, m_miss()});
    endtask

    task automatic model_edge();
        logic [31:0] nxt;
`ifdef PC_UNIT_EXC_EN
        if (bus.exc_req) begin
            m_pc = EXC_VEC;
            m_ras.delete();
            return;
        end
`endif
        if (bus.stall) return;
        nxt = m_npc();
        if (bus.npc_op == 3'd4 || bus.npc_op == 3'd5) begin
            m_ras.push_back(m_pc + 32'd4);
            if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end else if (bus.npc_op == 3'd6 && m_ras.size() > 0) begin
            void'(m_ras.pop_back());
        end
        m_pc = nxt;
    endtask

    task automatic drive(input logic [2:0] op, input logic st, input logic bt,
                         input logic [15:0] i16, input logic [25:0] i26, input logic [31:0] a);
        bus.npc_op   = op;
        bus.stall    = st;
        bus.br_taken = bt;
        bus.imm16    = i16;
        bus.imm26    = i26;
        bus.addr     = a;
    endtask

    task automatic cycle();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Asserts reset mid-cycle, checks the cleared state, holds through one edge, releases after it.
    task automatic do_reset();
        reset = 1'b0;
        m_pc  = RESET_PC;
        m_ras.delete();
        #2;
        chk("rst_pc",    bus.pc, RESET_PC);
        chk("rst_empty", {31'b0, bus.ras_empty}, 32'd1);
        chk("rst_full",  {31'b0, bus.ras_full},  32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    logic [31:0] links [5];

    initial begin
        reset = 1'b0;
`ifdef PC_UNIT_EXC_EN
        bus.exc_req = 1'b0;
`endif
        drive(3'd0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
        @(posedge clk);
        #1;
        do_reset();

        // Sequential flow
        for (int i = 1; i <= 4; i++) begin
            drive(3'd0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
            cycle();
            chk("seq_pc", bus.pc, 32'h3000 + 32'(i * 4));
        end

        // Branch at 0x3010
        drive(3'd1, 1'b0, 1'b1, 16'hFFFC, 26'h0, 32'h0);
        #1 chk("br_taken_npc", bus.npc, 32'h0000_3004);
        drive(3'd1, 1'b0, 1'b0, 16'hFFFC, 26'h0, 32'h0);
        #1 chk("br_not_npc", bus.npc, 32'h0000_3014);
        cycle();

        // jal then matching return
        do_reset();
        drive(3'd4, 1'b0, 1'b0, 16'h0, 26'h0000C10, 32'h0);
        cycle();
        chk("jal_pc", bus.pc, 32'h0000_3040);
        chk("model_top", m_ras[$], 32'h0000_3004);
        drive(3'd6, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0000_3004);
        #1 chk("ret_hit_miss", {31'b0, bus.ras_miss}, 32'd0);
        cycle();
        chk("ret_pc", bus.pc, 32'h0000_3004);
        chk("ret_empty", {31'b0, bus.ras_empty}, 32'd1);

        // Overflow: five pushes into four entries
        do_reset();
        for (int i = 0; i < 5; i++) begin
            links[i] = bus.pc + 32'd4;
            drive(3'd4, 1'b0, 1'b0, 16'h0, 26'h0000C10 + 26'(16 * i), 32'h0);
            cycle();
        end
        chk("link_e", links[4], 32'h0000_3104);
        chk("ovf_full", {31'b0, bus.ras_full}, 32'd1);
        drive(3'd6, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0000_1234);
        #1 chk("ret_wrong_miss", {31'b0, bus.ras_miss}, 32'd1);
        for (int i = 4; i >= 1; i--) begin
            drive(3'd6, 1'b0, 1'b0, 16'h0, 26'h0, links[i]);
            #1 chk("pop_miss", {31'b0, bus.ras_miss}, 32'd0);
            cycle();
            chk("pop_pc", bus.pc, links[i]);
        end
        chk("drain_empty", {31'b0, bus.ras_empty}, 32'd1);
        drive(3'd6, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0000_5000);
        #1 chk("empty_ret_miss", {31'b0, bus.ras_miss}, 32'd0);
        cycle();
        chk("empty_ret_pc", bus.pc, 32'h0000_5000);

        // Stall holds everything; illegal opcode goes to RESET_PC
        drive(3'd4, 1'b1, 1'b0, 16'h0, 26'h0000C10, 32'h0);
        cycle();
        cycle();
        chk("stall_pc", bus.pc, 32'h0000_5000);
        chk("stall_empty", {31'b0, bus.ras_empty}, 32'd1);
        drive(3'd7, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
        #1 chk("illegal_npc", bus.npc, 32'h0000_3000);
        cycle();

`ifdef PC_UNIT_EXC_EN
        do_reset();
        drive(3'd4, 1'b0, 1'b0, 16'h0, 26'h0000C10, 32'h0);
        cycle();
        cycle();
        drive(3'd0, 1'b1, 1'b0, 16'h0, 26'h0, 32'h0);
        bus.exc_req = 1'b1;
        cycle();
        bus.exc_req = 1'b0;
        chk("exc_pc", bus.pc, 32'h0000_4180);
        chk("exc_empty", {31'b0, bus.ras_empty}, 32'd1);
`endif

        // Randomized traffic, weighted towards calls and returns
        for (int n = 0; n < 3000; n++) begin
            int r;
            logic [2:0]  op;
            logic [31:0] a;
            r = int'($urandom_range(0, 9));
            if (r <= 2)      op = ($urandom_range(0, 1) == 0) ? 3'd4 : 3'd5;
            else if (r <= 4) op = 3'd6;
            else             op = 3'($urandom_range(0, 7));
            a = {$urandom_range(0, 32'hFFFF), 2'b00} + 32'h0000_3000;
            if (op == 3'd6 && m_ras.size() > 0 && $urandom_range(0, 1) == 0) a = m_ras[$];
            drive(op, $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)),
                  16'($urandom), 26'($urandom), a);
`ifdef PC_UNIT_EXC_EN
            bus.exc_req = ($urandom_range(0, 19) == 0);
`endif
            if ($urandom_range(0, 199) == 0) do_reset();
            else cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/pc_unit.md
# pc_unit

Registered program-counter unit for the single-cycle MIPS datapath. It holds the architectural PC and computes the next PC for sequential, branch, jump and register-jump flow. It adds a parametrised-depth return-address stack (RAS) that tracks `jal`/`jalr` calls and flags return mispredictions. It sits between instruction memory (drives `pc`) and the controller/GRF (consumes `pc4` for link writes).

## Interface
- `RESET_PC`, 32'h0000_3000: PC value after reset and the `npc` value for illegal opcodes.
- `RAS_DEPTH`, 4: number of RAS entries; power of two, minimum 2.
- `EXC_VECTOR`, 32'h0000_4180: exception handler address; used only when `PC_UNIT_EXC_EN` is defined.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `stall` input 1: hold PC and RAS for this cycle.
- `npc_op` input 3: next-PC mode (see Operation).
- `br_taken` input 1: branch condition from ALU; meaningful only when `npc_op`=001.
- `imm16` input 16: branch offset field.
- `imm26` input 26: jump index field.
- `addr` input 32: register-jump target (GPR[rs]).
- `exc_req` input 1: exception request; port exists only with `PC_UNIT_EXC_EN`.
- `pc` output 32: current PC register.
- `npc` output 32: combinational next PC.
- `pc4` output 32: `pc`+4, the link value.
- `ras_empty` output 1: RAS holds no entries.
- `ras_full` output 1: RAS holds `RAS_DEPTH` entries.
- `ras_miss` output 1: combinational; high when `npc_op`=110, RAS is non-empty, and RAS top != `addr`.

## Operation
- `npc_op` encoding; all arithmetic is modulo 2^32:
  - 000 seq: `npc`=`pc`+4.
  - 001 beq-class: `npc`=`pc`+4+sext(`imm16`)<<2 if `br_taken`, else `pc`+4.
  - 010 j: `npc`={`pc`[31:28],`imm26`,2'b00}.
  - 011 jr (non-return): `npc`=`addr`; the RAS is untouched.
  - 100 jal: same target as 010; push `pc4`.
  - 101 jalr: `npc`=`addr`; push `pc4`.
  - 110 ret (`jr $ra`): `npc`=`addr` (architectural target always wins); pop if non-empty.
  - 111 illegal: `npc`=`RESET_PC`; RAS is untouched.
- RAS is a circular buffer with a top pointer and an occupancy count (0..`RAS_DEPTH`).
- Push when full overwrites the oldest entry. The count saturates at `RAS_DEPTH` and `ras_full` stays high.
- Pop when empty is a no-op. `ras_miss` stays 0.
- `ras_empty`/`ras_full` are decoded from the registered count.
- Push/pop/PC update happen only on an edge with `stall`=0. When `stall`=1, `npc` and `ras_miss` still evaluate but no state changes.

## Timing
- Reset (asynchronous assert, synchronous to `clk` on release): `pc`=`RESET_PC`, count=0, top pointer=0, `ras_empty`=1, `ras_full`=0, `ras_miss`=0.
  - RAS entry contents are don't-care after reset and must never be observable.
- Reset asserted mid-operation clears PC and RAS immediately, regardless of `stall`.
- `npc`, `pc4` and `ras_miss` are purely combinational from the current `pc`, RAS state and inputs; they have zero-cycle latency.
- `pc` <= `npc` on each unstalled rising edge, so a new PC is seen one cycle after its op is presented.
- A pushed entry is visible to a `ret` in the very next unstalled cycle. Back-to-back push then pop returns the pushed value.

## Configuration
- `PC_UNIT_EXC_EN` defined:
  - The `exc_req` port exists.
  - `exc_req`=1 forces `npc`=`EXC_VECTOR`, overriding every `npc_op`.
  - On the edge, `pc` loads `EXC_VECTOR` even if `stall`=1.
  - The RAS is flushed to empty and no push/pop occurs that cycle.
- Undefined: the port, vector and flush logic are absent; behaviour is exactly as above.

## Test plan
- Reset release, `npc_op`=000 for 3 cycles -> `pc` = 0x3000, 0x3004, 0x3008, 0x300C; `ras_empty`=1.
- At `pc`=0x3010, `npc_op`=001, `imm16`=16'hFFFC, `br_taken`=1 -> `npc`=0x3004. Same with `br_taken`=0 -> 0x3014.
- At `pc`=0x3000, `npc_op`=100, `imm26`=26'h0000C10 -> next `pc`=0x3040 and RAS top=0x3004. Then `npc_op`=110, `addr`=0x3004 -> `ras_miss`=0, `pc`=0x3004, `ras_empty`=1.
- Push 5 times with `RAS_DEPTH`=4 (links A..E) -> `ras_full`=1. Pops return E, D, C, B, then `ras_empty`=1. A fifth `ret` with `addr`=0x5000 -> `pc`=0x5000, `ras_miss`=0.
- `stall`=1 with `npc_op`=100 for 2 cycles -> `pc` unchanged and the RAS count unchanged. `npc_op`=111 -> `npc`=0x3000.
- With `PC_UNIT_EXC_EN`: two pushes, then `exc_req`=1 with `stall`=1 -> `pc`=0x4180 and `ras_empty`=1 next cycle.
